// File: rtl/spi_cmd_log_iomem_pkg.sv
// Shared definitions for the SPI command log: iomem register offsets, log entry layout
// and the handshake state encoding.
package spi_cmd_log_iomem_pkg;

  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_HEAD0  = 8'h04;
  localparam logic [7:0] REG_HEAD1  = 8'h08;
  localparam logic [7:0] REG_HEAD2  = 8'h0C;
  localparam logic [7:0] REG_POP    = 8'h10;
  localparam logic [7:0] REG_CTRL   = 8'h14;

  localparam logic [31:0] RDATA_DEFAULT = 32'hDECAFBAD;

  localparam int unsigned TS_W    = 24;
  localparam int unsigned CMD_W   = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 12;
  localparam int unsigned ENTRY_W = TS_W + CMD_W + ADDR_W + LEN_W;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ACK,
    BUS_WAIT
  } bus_state_t;

  function automatic logic [31:0] status_word(input logic [15:0] dropped, input logic full,
                                              input logic empty, input logic [7:0] count);
    return {dropped, 6'b0, full, empty, count};
  endfunction

endpackage

// File: rtl/spi_cmd_log_iomem_if.sv
// iomem slave bus as seen by the command log: request from picosoc, registered completion back.
interface spi_cmd_log_iomem_if;
  logic        sel;
  logic [7:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output sel, addr, wstrb, wdata, input rdata, ready);
  modport slave  (input sel, addr, wstrb, wdata, output rdata, ready);
endinterface

// File: rtl/spi_cmd_log_iomem_fifo.sv
// Synchronous FIFO for command log entries: unreset storage array plus a registered head word.
module spi_cmd_fifo #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned WIDTH      = 76
) (
  input  logic                  clk_16mhz,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic                  push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty && !clear;
  assign push_ok = push && !clear && (!full || pop_ok);
  assign rd_nxt  = clear ? '0 : rd_ptr_q + DEPTH_LOG2'(pop_ok);

  always_ff @(posedge clk_16mhz) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  // Head is read at the pointer it will have next cycle; a write landing there bypasses the array.
  always_ff @(posedge clk_16mhz) begin
    head <= (push_ok && (wr_ptr_q == rd_nxt)) ? din : mem[rd_nxt];
  end

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      rd_ptr_q <= rd_nxt;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_log_iomem.sv
// Timestamped log of uspispy flash commands, drained by picosoc firmware over iomem.
module spi_cmd_log_iomem
  import spi_cmd_log_iomem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                      clk_16mhz,
  input  logic                      resetn,
  input  logic                      spi_cmd_strobe,
  input  logic [7:0]                spi_cmd,
  input  logic [31:0]               spi_addr,
  input  logic [11:0]               spi_len,
  spi_cmd_log_iomem_if.slave        bus,
  output logic                      irq
);

  bus_state_t          state_q, state_d;
  logic [27:0]         tick_q;
  logic                capture_en_q, irq_en_q;
  logic [15:0]         dropped_q;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  cmd_entry_t          head, push_entry;
  logic                ack, bus_wr, pop_req, pop_ok, ctrl_wr, clear, push_req;
  logic [31:0]         rd_mux;

  assign ack        = (state_q == BUS_ACK);
  assign bus.ready  = ack;
  assign bus_wr     = ack && bus.sel && (bus.wstrb != 4'b0000);
  assign pop_req    = bus_wr && (bus.addr == REG_POP);
  assign pop_ok     = pop_req && !fifo_empty;
  assign ctrl_wr    = ack && bus.sel && bus.wstrb[0] && (bus.addr == REG_CTRL);
  assign clear      = ctrl_wr && bus.wdata[2];
  assign push_req   = spi_cmd_strobe && capture_en_q && !clear;
  assign push_entry = '{ts: tick_q[27:4], cmd: spi_cmd, addr: spi_addr, len: spi_len};

  spi_cmd_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk_16mhz (clk_16mhz),
    .resetn    (resetn),
    .push      (push_req),
    .pop       (pop_req),
    .clear     (clear),
    .din       (push_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  // One ready per sel assertion: after the ack, wait for sel to drop before re-arming.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (bus.sel) state_d = BUS_ACK;
      BUS_ACK:  state_d = bus.sel ? BUS_WAIT : BUS_IDLE;
      BUS_WAIT: if (!bus.sel) state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = RDATA_DEFAULT;
    case (bus.addr)
      REG_STATUS: rd_mux = status_word(dropped_q, fifo_full, fifo_empty, 8'(fifo_count));
      REG_HEAD0:  rd_mux = fifo_empty ? '0 : {head.ts, head.cmd};
      REG_HEAD1:  rd_mux = fifo_empty ? '0 : head.addr;
      REG_HEAD2:  rd_mux = fifo_empty ? '0 : {20'h0, head.len};
      REG_POP:    rd_mux = '0;
      REG_CTRL:   rd_mux = {30'h0, irq_en_q, capture_en_q};
      default:    rd_mux = RDATA_DEFAULT;
    endcase
  end

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      state_q      <= BUS_IDLE;
      bus.rdata    <= '0;
      tick_q       <= '0;
      capture_en_q <= 1'b1;
      irq_en_q     <= 1'b0;
      dropped_q    <= '0;
      irq          <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus.rdata <= (state_q == BUS_IDLE && bus.sel) ? rd_mux : '0;
      tick_q    <= tick_q + 1'b1;
      irq       <= irq_en_q && !fifo_empty;
      if (ctrl_wr) begin
        capture_en_q <= bus.wdata[0];
        irq_en_q     <= bus.wdata[1];
      end
      if (clear)
        dropped_q <= '0;
      else if (push_req && fifo_full && !pop_ok && (dropped_q != '1))
        dropped_q <= dropped_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_log_iomem.sv
// Directed bench for spi_cmd_log_iomem: transactions queue their expected rdata, a monitor
// compares on every ready pulse.
module tb_spi_cmd_log_iomem;

  logic        clk_16mhz = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_cmd_strobe = 1'b0;
  logic [7:0]  spi_cmd = '0;
  logic [31:0] spi_addr = '0;
  logic [11:0] spi_len = '0;
  logic        irq;

  spi_cmd_log_iomem_if bus ();

  spi_cmd_log_iomem #(.DEPTH_LOG2(5)) dut (
    .clk_16mhz      (clk_16mhz),
    .resetn         (resetn),
    .spi_cmd_strobe (spi_cmd_strobe),
    .spi_cmd        (spi_cmd),
    .spi_addr       (spi_addr),
    .spi_len        (spi_len),
    .bus            (bus),
    .irq            (irq)
  );

  always #31 clk_16mhz = ~clk_16mhz;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
    logic [31:0] mask;
    bit          tol;
    bit          chk;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_vec = 0, n_miss = 0, mon_vec = 0, mon_miss = 0, rdy_cnt = 0, cyc = 0;
  exp_t        m_e;
  bit          m_ok;
  int          m_d;

  always @(posedge clk_16mhz) begin
    if (!resetn) cyc = 0;
    else cyc = cyc + 1;
  end

  always @(negedge clk_16mhz) begin
    if (bus.ready === 1'b1) begin
      rdy_cnt = rdy_cnt + 1;
      if (expq.size() == 0) begin
        mon_vec = mon_vec + 1;
        mon_miss = mon_miss + 1;
        $display("FAIL unexpected_ready: rdata=%08h with no transaction outstanding", bus.rdata);
      end else begin
        m_e = expq.pop_front();
        if (m_e.chk) begin
          mon_vec = mon_vec + 1;
          if (m_e.tol) begin
            m_d  = int'(bus.rdata[31:8]) - int'(m_e.exp[31:8]);
            m_ok = (bus.rdata[7:0] == m_e.exp[7:0]) && (m_d >= -1) && (m_d <= 1);
          end else begin
            m_ok = (((bus.rdata ^ m_e.exp) & m_e.mask) == 32'h0);
          end
          if (!m_ok) begin
            mon_miss = mon_miss + 1;
            $display("FAIL rd_%02h: rdata=%08h required %08h (mask %08h)",
                     m_e.addr, bus.rdata, m_e.exp, m_e.mask);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %08h required %08h", nm, act, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge; leaves one idle cycle with sel low.
  task automatic xfer(input logic [7:0] a, input logic [3:0] ws, input logic [31:0] wd,
                      input logic [31:0] exp, input logic [31:0] mask, input bit tol,
                      input bit chk_en, input bit strobe_rdy, input logic [7:0] scmd);
    bit   got;
    exp_t e;
    e.addr = a; e.exp = exp; e.mask = mask; e.tol = tol; e.chk = chk_en;
    expq.push_back(e);
    bus.sel = 1'b1; bus.addr = a; bus.wstrb = ws; bus.wdata = wd;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_16mhz); #1;
      if (bus.ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec = n_vec + 1;
      n_miss = n_miss + 1;
      $display("FAIL timeout_%02h: ready=0 required 1 within 8 cycles", a);
      void'(expq.pop_back());
    end else if (strobe_rdy) begin
      spi_cmd_strobe = 1'b1; spi_cmd = scmd; spi_addr = {24'h0, scmd}; spi_len = 12'h001;
    end
    @(posedge clk_16mhz); #1;
    bus.sel = 1'b0; bus.wstrb = 4'h0; spi_cmd_strobe = 1'b0;
    @(posedge clk_16mhz); #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    xfer(a, 4'h0, 32'h0, exp, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 8'h0);
  endtask

  task automatic rdm(input logic [7:0] a, input logic [31:0] exp, input logic [31:0] mask);
    xfer(a, 4'h0, 32'h0, exp, mask, 1'b0, 1'b1, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    xfer(a, 4'hF, wd, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic strobe(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
    spi_cmd_strobe = 1'b1; spi_cmd = c; spi_addr = a; spi_len = l;
    @(posedge clk_16mhz); #1;
    spi_cmd_strobe = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ts_exp;
    int unsigned rdy0;
    exp_t        e;
    bus.sel = 1'b0; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
    repeat (3) @(posedge clk_16mhz);
    #1;
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    resetn = 1'b1;

    // Reset register values and the unmapped default
    rd(8'h00, 32'h0000_0100);
    rd(8'h14, 32'h0000_0001);
    rd(8'h20, 32'hDECA_FBAD);
    rd(8'h10, 32'h0000_0000);

    // Single entry at tick 160, POP using a non-zero upper byte strobe only
    while (cyc < 160) begin
      @(posedge clk_16mhz); #1;
    end
    ts_exp = 24'(cyc >> 4);
    strobe(8'h03, 32'h00FF_0000, 12'h100);
    rd(8'h00, 32'h0000_0001);
    xfer(8'h04, 4'h0, 32'h0, {ts_exp, 8'h03}, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 8'h0);
    rd(8'h08, 32'h00FF_0000);
    rd(8'h0C, 32'h0000_0100);
    xfer(8'h10, 4'h2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    rd(8'h00, 32'h0000_0100);
    rd(8'h08, 32'h0000_0000);

    // Overflow: 34 pushes into 32 entries, then drain in order
    for (int i = 0; i < 34; i++) strobe(8'(128 + i), 32'(i), 12'(i));
    rd(8'h00, 32'h0002_0220);
    for (int i = 0; i < 32; i++) begin
      rdm(8'h04, {24'h0, 8'(128 + i)}, 32'h0000_00FF);
      wr(8'h10, 32'h0);
    end
    rd(8'h00, 32'h0002_0100);

    // Full with a push in the POP ready cycle
    for (int i = 0; i < 32; i++) strobe(8'(64 + i), 32'(i), 12'(i));
    rd(8'h00, 32'h0002_0220);
    xfer(8'h10, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'hEE);
    rd(8'h00, 32'h0002_0220);
    for (int i = 0; i < 32; i++) begin
      rdm(8'h04, {24'h0, (i < 31) ? 8'(65 + i) : 8'hEE}, 32'h0000_00FF);
      wr(8'h10, 32'h0);
    end
    rd(8'h00, 32'h0002_0100);

    // IRQ timing, CTRL byte strobe, CLEAR with a simultaneous strobe
    wr(8'h14, 32'h3);
    xfer(8'h14, 4'h2, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    rd(8'h14, 32'h0000_0003);
    strobe(8'h11, 32'h1111, 12'h011);
    chk("irq_same_cycle", {31'h0, irq}, 32'h0);
    @(posedge clk_16mhz); #1;
    chk("irq_one_later", {31'h0, irq}, 32'h1);
    wr(8'h10, 32'h0);
    @(posedge clk_16mhz); #1;
    chk("irq_after_pop", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) strobe(8'(32 + i), 32'h0, 12'h0);
    repeat (2) @(posedge clk_16mhz);
    #1;
    chk("irq_three", {31'h0, irq}, 32'h1);
    rd(8'h00, 32'h0002_0003);
    xfer(8'h14, 4'hF, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h77);
    rd(8'h00, 32'h0000_0100);
    rd(8'h14, 32'h0000_0001);
    chk("irq_after_clear", {31'h0, irq}, 32'h0);

    // sel held for 5 cycles on a POP write
    wr(8'h14, 32'h3);
    strobe(8'h21, 32'h0, 12'h0);
    strobe(8'h22, 32'h0, 12'h0);
    repeat (2) @(posedge clk_16mhz);
    #1;
    rdy0 = rdy_cnt;
    e.addr = 8'h10; e.exp = 32'h0; e.mask = 32'h0; e.tol = 1'b0; e.chk = 1'b0;
    expq.push_back(e);
    bus.sel = 1'b1; bus.addr = 8'h10; bus.wstrb = 4'hF; bus.wdata = 32'h0;
    repeat (5) @(posedge clk_16mhz);
    #1;
    bus.sel = 1'b0; bus.wstrb = 4'h0;
    repeat (2) @(posedge clk_16mhz);
    #1;
    chk("hold_pulses", 32'(rdy_cnt - rdy0), 32'h1);
    rd(8'h00, 32'h0000_0001);
    rdm(8'h04, 32'h0000_0022, 32'h0000_00FF);

    // Reset asserted while a POP is in its ready cycle
    chk("irq_before_reset", {31'h0, irq}, 32'h1);
    expq.push_back(e);
    bus.sel = 1'b1; bus.addr = 8'h10; bus.wstrb = 4'hF;
    @(posedge clk_16mhz); #1;
    chk("mid_ready", {31'h0, bus.ready}, 32'h1);
    resetn = 1'b0;
    @(posedge clk_16mhz); #1;
    chk("mid_rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("mid_rst_rdata", bus.rdata, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    bus.sel = 1'b0; bus.wstrb = 4'h0;
    @(posedge clk_16mhz); #1;
    resetn = 1'b1;
    rd(8'h00, 32'h0000_0100);
    rd(8'h14, 32'h0000_0001);
    rd(8'h04, 32'h0000_0000);

    chk("queue_drained", 32'(expq.size()), 32'h0);
    n_vec = n_vec + mon_vec;
    n_miss = n_miss + mon_miss;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
